// File: rtl/aud_pwm_driver.sv
// Audio PWM driver with amplifier wake-up sequencing and frame-synchronous duty updates.
// Define AUD_FADE_EN to build the volume fade-out stage that runs when enable is dropped.
module aud_pwm_driver #(
  parameter int PWM_BITS    = 8,
  parameter int WAKE_CYCLES = 1000000,
  parameter int FADE_FRAMES = 256
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       audio,
  input  logic       enable,
  input  logic [2:0] volume,
  output logic       AUD_PWM,
  output logic       AUD_SD,
  output logic       active
);

  localparam int                HALF_I      = 2 ** (PWM_BITS - 1);
  localparam logic [PWM_BITS:0] HALF        = HALF_I[PWM_BITS:0];
  localparam int                WAKE_W      = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int                WAKE_LOAD_I = WAKE_CYCLES - 1;
  localparam logic [WAKE_W-1:0] WAKE_LOAD   = WAKE_LOAD_I[WAKE_W-1:0];

`ifdef AUD_FADE_EN
  localparam int                FADE_W      = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam int                FADE_LAST_I = FADE_FRAMES - 1;
  localparam logic [FADE_W-1:0] FADE_LAST   = FADE_LAST_I[FADE_W-1:0];

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_RUN, S_FADE} state_t;
  logic [FADE_W-1:0] r_fade;
`else
  typedef enum logic [1:0] {S_OFF, S_WAKE, S_RUN} state_t;
`endif

  state_t              r_state;
  logic [PWM_BITS-1:0] r_cnt;
  logic [WAKE_W-1:0]   r_wake;
  logic                r_audio_q;
  logic [2:0]          r_vol_q;
  logic [2:0]          r_eff_vol;
  logic                r_pwm;
  logic                r_sd;
  logic                r_active;

  logic                w_frame_end;
  logic [PWM_BITS:0]   w_delta;
  logic [PWM_BITS:0]   w_duty;
  logic                w_hi;

  // Duty swings symmetrically around 50% in steps of 1/16 frame per volume level.
  assign w_frame_end = (r_cnt == '1);
  assign w_delta     = {{(PWM_BITS-2){1'b0}}, r_eff_vol} << (PWM_BITS - 4);
  assign w_duty      = r_audio_q ? (HALF + w_delta) : (HALF - w_delta);
  assign w_hi        = ({1'b0, r_cnt} < w_duty);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_cnt     <= '0;
      r_audio_q <= 1'b0;
      r_vol_q   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_frame_end) begin
        r_audio_q <= audio;
        r_vol_q   <= volume;
      end
    end
  end

  // Outputs default to "amplifier on, PWM follows compare"; any branch landing in OFF overrides them.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state   <= S_OFF;
      r_wake    <= '0;
      r_eff_vol <= '0;
      r_pwm     <= 1'b0;
      r_sd      <= 1'b0;
      r_active  <= 1'b0;
`ifdef AUD_FADE_EN
      r_fade    <= '0;
`endif
    end else begin
      r_pwm    <= w_hi;
      r_sd     <= 1'b1;
      r_active <= 1'b0;
      case (r_state)
        S_OFF: begin
          r_eff_vol <= '0;
          if (enable) begin
            r_state <= S_WAKE;
            r_wake  <= WAKE_LOAD;
          end else begin
            r_pwm <= 1'b0;
            r_sd  <= 1'b0;
          end
        end
        S_WAKE: begin
          if (!enable) begin
            r_state <= S_OFF;
            r_pwm   <= 1'b0;
            r_sd    <= 1'b0;
          end else if (r_wake == '0) begin
            r_state  <= S_RUN;
            r_active <= 1'b1;
          end else begin
            r_wake <= r_wake - 1'b1;
          end
        end
        S_RUN: begin
          r_active <= 1'b1;
          if (w_frame_end) r_eff_vol <= r_vol_q;
`ifdef AUD_FADE_EN
          if (!enable) begin
            r_state  <= S_FADE;
            r_active <= 1'b0;
            r_fade   <= '0;
          end
`else
          if (!enable && w_frame_end) begin
            r_state   <= S_OFF;
            r_active  <= 1'b0;
            r_sd      <= 1'b0;
            r_pwm     <= 1'b0;
            r_eff_vol <= '0;
          end
`endif
        end
`ifdef AUD_FADE_EN
        S_FADE: begin
          if (enable) begin
            r_state  <= S_RUN;
            r_active <= 1'b1;
          end else if (w_frame_end) begin
            if (r_eff_vol == '0) begin
              r_state <= S_OFF;
              r_sd    <= 1'b0;
              r_pwm   <= 1'b0;
            end else if (r_fade == FADE_LAST) begin
              r_eff_vol <= r_eff_vol - 3'd1;
              r_fade    <= '0;
            end else begin
              r_fade <= r_fade + 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= S_OFF;
          r_pwm   <= 1'b0;
          r_sd    <= 1'b0;
        end
      endcase
    end
  end

  assign AUD_PWM = r_pwm;
  assign AUD_SD  = r_sd;
  assign active  = r_active;

endmodule

// File: tb/tb_aud_pwm_driver.sv
// Directed self-checking bench for aud_pwm_driver (WAKE_CYCLES=1000, FADE_FRAMES=2).
// Frame duty is measured by counting AUD_PWM high cycles over one aligned 256-clock frame.
module tb_aud_pwm_driver;

  logic       clk;
  logic       rst_n;
  logic       audio;
  logic       enable;
  logic [2:0] volume;
  logic       aud_pwm;
  logic       aud_sd;
  logic       active;

  int         vec  = 0;
  int         errs = 0;
  int         cyc  = 0;
  logic [7:0] m_cnt;

  aud_pwm_driver #(
    .PWM_BITS    (8),
    .WAKE_CYCLES (1000),
    .FADE_FRAMES (2)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .audio      (audio),
    .enable     (enable),
    .volume     (volume),
    .AUD_PWM    (aud_pwm),
    .AUD_SD     (aud_sd),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Time reference: expected carrier position, restarted by reset like the DUT's.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 8'd0;
    else        m_cnt <= m_cnt + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Waits for the negedge where the first PWM sample of a frame is visible, then counts 256 samples.
  // Returns on the negedge just after the next frame boundary (m_cnt == 0).
  task automatic count_high(input int toggle_at, output int hi);
    int guard;
    guard = 0;
    hi    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_cnt != 8'd1 && guard < 300);
    if (m_cnt != 8'd1) begin
      vec++;
      errs++;
      $error("FAIL frame_sync: observed %0d expected 1", m_cnt);
    end
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (aud_pwm === 1'b1) hi++;
      if (int'(m_cnt) == toggle_at) audio = ~audio;
    end
  endtask

  task automatic wake_seq(input bit measure);
    int c0;
    int hi;
    enable = 1'b1;
    @(negedge clk);
    c0 = cyc;
    check("wake_sd_on", aud_sd, 1);
    check("wake_inactive", active, 0);
    if (measure) begin
      count_high(-1, hi);
      check("wake_duty_128", hi, 128);
    end
    step_to(c0 + 999);
    check("wake_999_inactive", active, 0);
    @(negedge clk);
    check("wake_1000_active", active, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst_n  = 1'b0;
    audio  = 1'b0;
    enable = 1'b0;
    volume = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", aud_pwm, 0);
    check("rst_sd", aud_sd, 0);
    check("rst_active", active, 0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("off_sd", aud_sd, 0);
    check("off_pwm", aud_pwm, 0);

    // Wake with a loud tone requested: wake duty must stay at 50%.
    audio  = 1'b1;
    volume = 3'd7;
    wake_seq(1'b1);

    repeat (256) @(negedge clk);
    count_high(-1, hi);
    check("run_v7_a1", hi, 240);
    audio = 1'b0;
    repeat (2) @(negedge clk);
    count_high(-1, hi);
    check("run_v7_a0", hi, 16);

    // Mid-frame toggle must not disturb the frame in progress.
    count_high(100, hi);
    check("toggle_cur_frame", hi, 16);
    count_high(-1, hi);
    check("toggle_next_frame", hi, 240);

    volume = 3'd0;
    repeat (600) @(negedge clk);
    count_high(-1, hi);
    check("v0_a1_half", hi, 128);
    audio = 1'b0;
    repeat (2) @(negedge clk);
    count_high(-1, hi);
    check("v0_a0_half", hi, 128);

    volume = 3'd4;
    audio  = 1'b1;
    repeat (600) @(negedge clk);
    count_high(-1, hi);
    check("run_v4_a1", hi, 192);

`ifdef AUD_FADE_EN
    enable = 1'b0;
    count_high(-1, hi); check("fade_a_f0", hi, 192);
    count_high(-1, hi); check("fade_a_f1", hi, 192);
    count_high(-1, hi); check("fade_a_f2", hi, 176);
    count_high(-1, hi); check("fade_a_f3", hi, 176);
    count_high(-1, hi); check("fade_a_f4", hi, 160);
    enable = 1'b1;
    count_high(-1, hi); check("refire_hold", hi, 160);
    count_high(-1, hi); check("refire_reload", hi, 192);
    check("refire_active", active, 1);

    enable = 1'b0;
    count_high(-1, hi); check("fade_b_f0", hi, 192);
    count_high(-1, hi); check("fade_b_f1", hi, 192);
    count_high(-1, hi); check("fade_b_f2", hi, 176);
    count_high(-1, hi); check("fade_b_f3", hi, 176);
    count_high(-1, hi); check("fade_b_f4", hi, 160);
    count_high(-1, hi); check("fade_b_f5", hi, 160);
    count_high(-1, hi); check("fade_b_f6", hi, 144);
    count_high(-1, hi); check("fade_b_f7", hi, 144);
    count_high(-1, hi); check("fade_b_f8", hi, 128);
    check("fade_off_sd", aud_sd, 0);
    check("fade_off_pwm", aud_pwm, 0);
    check("fade_off_active", active, 0);
`else
    enable = 1'b0;
    @(negedge clk);
    check("drop_sd_hold", aud_sd, 1);
    while (m_cnt != 8'd255) @(negedge clk);
    check("drop_sd_last", aud_sd, 1);
    check("drop_active_last", active, 1);
    @(negedge clk);
    check("drop_off_sd", aud_sd, 0);
    check("drop_off_active", active, 0);
    check("drop_off_pwm", aud_pwm, 0);
`endif
    count_high(-1, hi);
    check("off_frame_silent", hi, 0);

    // Abort the wake half-way, then require the full delay again.
    begin
      int c0;
      enable = 1'b1;
      @(negedge clk);
      c0 = cyc;
      check("abort_sd_on", aud_sd, 1);
      step_to(c0 + 499);
      enable = 1'b0;
      @(negedge clk);
      check("abort_sd_off", aud_sd, 0);
      check("abort_active", active, 0);
      @(negedge clk);
      check("abort_pwm", aud_pwm, 0);
    end
    wake_seq(1'b0);

    // Asynchronous reset pulse between clock edges while running.
    repeat (300) @(negedge clk);
    check("pre_rst_sd", aud_sd, 1);
    check("pre_rst_active", active, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", aud_pwm, 0);
    check("async_rst_sd", aud_sd, 0);
    check("async_rst_active", active, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_off", aud_sd, 0);
    wake_seq(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
